// File: rtl/cpa_pkg.sv
// -----------------------------------------------------------------------------
// cpa_pkg
// Shared definitions for the CPA/TVLA stimulus generator:
//   - plaintext mode encodings (random, fixed-vs-random, sequential)
//   - controller state enumeration
//   - Galois LFSR feedback constant for x^128 + x^7 + x^2 + x + 1
//   - one-step LFSR helper used by the LFSR sub-module
// -----------------------------------------------------------------------------
package cpa_pkg;

  localparam logic [1:0] CPA_MODE_RAND = 2'd0;
  localparam logic [1:0] CPA_MODE_FVR  = 2'd1;
  localparam logic [1:0] CPA_MODE_SEQ  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } cpa_state_e;

  localparam logic [127:0] CPA_LFSR_POLY = 128'h87;

  // Galois step: shift left, fold the bit that falls off back in through the taps.
  function automatic logic [127:0] cpa_lfsr_next(input logic [127:0] s);
    cpa_lfsr_next = {s[126:0], 1'b0} ^ (s[127] ? CPA_LFSR_POLY : 128'h0);
  endfunction

endpackage

// File: rtl/cpa_lfsr128.sv
// -----------------------------------------------------------------------------
// cpa_lfsr128
// 128-bit Galois LFSR that supplies random plaintext material.
// Ports:
//   clk_text_input  in   1    clock, rising edge
//   reset           in   1    synchronous active-high; state <= seed
//   load            in   1    reload state from seed (wins over step)
//   seed            in   128  reload value (caller guarantees non-zero)
//   step            in   1    advance one LFSR step
//   state           out  128  current LFSR state
// -----------------------------------------------------------------------------
module cpa_lfsr128
  import cpa_pkg::*;
(
  input  logic         clk_text_input,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] seed,
  input  logic         step,
  output logic [127:0] state
);

  // LFSR state register: reset/load from seed, otherwise step on request.
  always_ff @(posedge clk_text_input) begin
    if (reset) begin
      state <= seed;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= cpa_lfsr_next(state);
    end
  end

endmodule

// File: rtl/cpa_stimulus_gen.sv
// -----------------------------------------------------------------------------
// cpa_stimulus_gen
// Plaintext/key source for CPA and TVLA capture. Issues NUM_TRACES blocks to
// the AES core over valid/ready, waits for aes_done, idles GAP_CYCLES, repeats.
// Ports:
//   clk_text_input  in   1       clock, rising edge
//   reset           in   1       synchronous active-high
//   start           in   1       starts a run from IDLE/DONE
//   abort           in   1       return to IDLE on the next edge
//   mode            in   2       0 random, 1 fixed-vs-random, 2 sequential, 3 as 0
//   text_ready      in   1       AES core accepts a block
//   aes_done        in   1       AES core finished the block in flight
//   text_valid      out  1       Text_to_AES/cypher_key valid
//   Text_to_AES     out  TEXT_W  plaintext
//   cypher_key      out  KEY_W   key (KEY once a run has started)
//   trace_idx       out  IDX_W   index of block presented / in flight
//   trace_class     out  1       TVLA class (1 fixed, 0 random)
//   trigger         out  1       scope trigger, high on the handshake cycle
//   busy            out  1       run in progress
//   done            out  1       run completed
// -----------------------------------------------------------------------------
module cpa_stimulus_gen
  import cpa_pkg::*;
#(
  parameter int                TEXT_W     = 128,
  parameter int                KEY_W      = 128,
  parameter logic [KEY_W-1:0]  KEY        = 128'h6efe8f326ab4878d12e98a9f7e6eb1a9,
  parameter logic [TEXT_W-1:0] FIXED_TEXT = 128'hda39a3ee5e6b4b0d3255bfef95601890,
  parameter logic [127:0]      SEED       = 128'h1,
  parameter int                NUM_TRACES = 256,
  parameter int                IDX_W      = 16,
  parameter int                GAP_CYCLES = 8
) (
  input  logic              clk_text_input,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              text_ready,
  input  logic              aes_done,
  output logic              text_valid,
  output logic [TEXT_W-1:0] Text_to_AES,
  output logic [KEY_W-1:0]  cypher_key,
  output logic [IDX_W-1:0]  trace_idx,
  output logic              trace_class,
  output logic              trigger,
  output logic              busy,
  output logic              done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [127:0]     SEED_EFF = (SEED == 128'h0) ? 128'h1 : SEED;
  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRACES - 1);
  localparam int               REP_N    = (TEXT_W + 127) / 128;

  cpa_state_e        state_r, state_nxt_s;
  logic [1:0]        mode_r, eff_mode_s;
  logic [IDX_W-1:0]  idx_r, idx_inc_s;
  logic [TEXT_W-1:0] text_r;
  logic              class_r;
  logic [KEY_W-1:0]  key_r;
  logic [GAP_W-1:0]  gap_r;
  logic [127:0]      lfsr_state_s;
  logic              hs_s, start_ok_s, done_ok_s, lfsr_step_s;

  // Builds {class, text} for one block; LFSR material repeats to fill wide texts.
  function automatic logic [TEXT_W:0] make_block(input logic [127:0] src,
                                                 input logic [1:0] md,
                                                 input logic [IDX_W-1:0] idx);
    logic [REP_N*128-1:0]    rep_wide;
    logic [TEXT_W+IDX_W-1:0] seq_ext;
    rep_wide = {REP_N{src}};
    seq_ext  = {{TEXT_W{1'b0}}, idx};
    case (md)
      CPA_MODE_FVR: make_block = src[0] ? {1'b1, FIXED_TEXT} : {1'b0, rep_wide[TEXT_W-1:0]};
      CPA_MODE_SEQ: make_block = {1'b0, seq_ext[TEXT_W-1:0]};
      default:      make_block = {1'b0, rep_wide[TEXT_W-1:0]};
    endcase
  endfunction

  assign eff_mode_s  = (mode == 2'd3) ? CPA_MODE_RAND : mode;
  assign idx_inc_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  // A handshake coinciding with abort or reset is dropped entirely.
  assign hs_s        = (state_r == ST_ISSUE) && text_ready && !abort && !reset;
  assign start_ok_s  = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign done_ok_s   = (state_r == ST_WAIT) && aes_done && !abort;
  assign lfsr_step_s = hs_s && (mode_r != CPA_MODE_SEQ);

  cpa_lfsr128 u_lfsr (
    .clk_text_input (clk_text_input),
    .reset          (reset),
    .load           (start_ok_s),
    .seed           (SEED_EFF),
    .step           (lfsr_step_s),
    .state          (lfsr_state_s)
  );

  // Controller state register.
  always_ff @(posedge clk_text_input) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) state_nxt_s = ST_ISSUE;
          else       state_nxt_s = state_r;
        end
        ST_ISSUE: begin
          if (text_ready) state_nxt_s = ST_WAIT;
          else            state_nxt_s = ST_ISSUE;
        end
        ST_WAIT: begin
          if (!aes_done)               state_nxt_s = ST_WAIT;
          else if (idx_r == LAST_IDX)  state_nxt_s = ST_DONE;
          else if (GAP_CYCLES == 0)    state_nxt_s = ST_ISSUE;
          else                         state_nxt_s = ST_GAP;
        end
        ST_GAP: begin
          if (gap_r == {GAP_W{1'b0}}) state_nxt_s = ST_ISSUE;
          else                        state_nxt_s = ST_GAP;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    text_valid = (state_r == ST_ISSUE);
    busy       = (state_r == ST_ISSUE) || (state_r == ST_WAIT) || (state_r == ST_GAP);
    done       = (state_r == ST_DONE);
    trigger    = hs_s;
  end

  // Block, index, key and gap registers; the next block is built once per accepted block.
  always_ff @(posedge clk_text_input) begin
    if (reset) begin
      mode_r  <= CPA_MODE_RAND;
      idx_r   <= {IDX_W{1'b0}};
      text_r  <= {TEXT_W{1'b0}};
      class_r <= 1'b0;
      key_r   <= {KEY_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
    end else if (!abort) begin
      if (start_ok_s) begin
        mode_r              <= eff_mode_s;
        idx_r               <= {IDX_W{1'b0}};
        key_r               <= KEY;
        {class_r, text_r}   <= make_block(SEED_EFF, eff_mode_s, {IDX_W{1'b0}});
      end else if (done_ok_s && (idx_r != LAST_IDX)) begin
        idx_r               <= idx_inc_s;
        {class_r, text_r}   <= make_block(lfsr_state_s, mode_r, idx_inc_s);
        gap_r               <= GAP_LOAD;
      end else if ((state_r == ST_GAP) && (gap_r != {GAP_W{1'b0}})) begin
        gap_r <= gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign Text_to_AES = text_r;
  assign trace_class = class_r;
  assign cypher_key  = key_r;
  assign trace_idx   = idx_r;

endmodule

// File: tb/tb_cpa_stimulus_gen.sv
// -----------------------------------------------------------------------------
// tb_cpa_stimulus_gen
// Four generator instances with different seeds, lengths and gaps share the
// control inputs; each has its own start and aes_done. Block expectations come
// from a vector table; corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cpa_stimulus_gen;

  localparam logic [127:0] KEY_C  = 128'h6efe8f326ab4878d12e98a9f7e6eb1a9;
  localparam logic [127:0] FIX_C  = 128'hda39a3ee5e6b4b0d3255bfef95601890;
  localparam logic [127:0] SEED1  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] SEED3  = 128'hf0e1d2c3b4a596870123456789abcdef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, abort, text_ready;
  logic [1:0]   mode;
  logic [3:0]   start, aes_done;
  logic [3:0]   tv, trig, busy, done, cls;
  logic [127:0] txt [4];
  logic [127:0] key [4];
  logic [15:0]  idx [4];

  int checks = 0;
  int errors = 0;

  cpa_stimulus_gen #(.SEED(128'h1), .NUM_TRACES(3), .GAP_CYCLES(8)) u_d0 (
    .clk_text_input(clk), .reset(reset), .start(start[0]), .abort(abort), .mode(mode),
    .text_ready(text_ready), .aes_done(aes_done[0]), .text_valid(tv[0]), .Text_to_AES(txt[0]),
    .cypher_key(key[0]), .trace_idx(idx[0]), .trace_class(cls[0]), .trigger(trig[0]),
    .busy(busy[0]), .done(done[0]));

  cpa_stimulus_gen #(.SEED(SEED1), .NUM_TRACES(4), .GAP_CYCLES(8)) u_d1 (
    .clk_text_input(clk), .reset(reset), .start(start[1]), .abort(abort), .mode(mode),
    .text_ready(text_ready), .aes_done(aes_done[1]), .text_valid(tv[1]), .Text_to_AES(txt[1]),
    .cypher_key(key[1]), .trace_idx(idx[1]), .trace_class(cls[1]), .trigger(trig[1]),
    .busy(busy[1]), .done(done[1]));

  cpa_stimulus_gen #(.SEED(128'h0), .NUM_TRACES(4), .GAP_CYCLES(0)) u_d2 (
    .clk_text_input(clk), .reset(reset), .start(start[2]), .abort(abort), .mode(mode),
    .text_ready(text_ready), .aes_done(aes_done[2]), .text_valid(tv[2]), .Text_to_AES(txt[2]),
    .cypher_key(key[2]), .trace_idx(idx[2]), .trace_class(cls[2]), .trigger(trig[2]),
    .busy(busy[2]), .done(done[2]));

  cpa_stimulus_gen #(.SEED(SEED3), .NUM_TRACES(64), .GAP_CYCLES(2)) u_d3 (
    .clk_text_input(clk), .reset(reset), .start(start[3]), .abort(abort), .mode(mode),
    .text_ready(text_ready), .aes_done(aes_done[3]), .text_valid(tv[3]), .Text_to_AES(txt[3]),
    .cypher_key(key[3]), .trace_idx(idx[3]), .trace_class(cls[3]), .trigger(trig[3]),
    .busy(busy[3]), .done(done[3]));

  typedef struct {
    int           dut;
    logic [1:0]   md;
    int           blk;
    logic [127:0] text;
    logic         cls;
    int           gap;
    bit           last;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input int d, input logic [1:0] m, input int b, input logic [127:0] t,
                     input logic c, input int g, input bit l);
    vec_t v;
    v.dut = d; v.md = m; v.blk = b; v.text = t; v.cls = c; v.gap = g; v.last = l;
    tbl.push_back(v);
  endtask

  function automatic logic [127:0] lfsr_model(input logic [127:0] s);
    lfsr_model = {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  task automatic start_run(input int k, input logic [1:0] m);
    mode     = m;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Waits for text_valid, accepts the block, optionally answers with aes_done.
  task automatic run_block(input int k, input bit send_done, output logic [127:0] t,
                           output logic c, output logic [15:0] ix);
    int n = 0;
    while (!tv[k] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("issue_wait", 128'(tv[k]), 128'd1);
    t  = txt[k];
    c  = cls[k];
    ix = idx[k];
    chk("key", key[k], KEY_C);
    text_ready = 1'b1;
    #1;
    chk("trig_on_hs", 128'(trig[k]), 128'd1);
    @(negedge clk);
    chk("valid_trig_drop", 128'({tv[k], trig[k]}), 128'd0);
    if (send_done) begin
      repeat (2) @(negedge clk);
      aes_done[k] = 1'b1;
      @(negedge clk);
      aes_done[k] = 1'b0;
    end
  endtask

  task automatic measure_gap(input int k, output int g);
    g = 0;
    while (!tv[k] && g < 40) begin
      g++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] t, s;
    logic         c;
    logic [15:0]  ix;
    int           g;
    vec_t         v;

    reset = 1'b1; abort = 1'b0; text_ready = 1'b1; mode = 2'd0;
    start = 4'd0; aes_done = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state of every instance.
    chk("rst_ctl", 128'({tv, trig, busy, done, cls}), 128'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_text d%0d", k), txt[k], 128'd0);
      chk($sformatf("rst_key d%0d", k), key[k], 128'd0);
      chk($sformatf("rst_idx d%0d", k), 128'(idx[k]), 128'd0);
    end

    // Directed vectors.
    add(0, 2'd0, 0, 128'h1, 1'b0, 8, 1'b0);
    add(0, 2'd0, 1, 128'h2, 1'b0, 8, 1'b0);
    add(0, 2'd0, 2, 128'h4, 1'b0, 8, 1'b1);
    add(0, 2'd3, 0, 128'h1, 1'b0, 8, 1'b0);
    add(0, 2'd3, 1, 128'h2, 1'b0, 8, 1'b0);
    add(0, 2'd3, 2, 128'h4, 1'b0, 8, 1'b1);
    add(1, 2'd0, 0, SEED1,    1'b0, 8, 1'b0);
    add(1, 2'd0, 1, 128'h87,  1'b0, 8, 1'b0);
    add(1, 2'd0, 2, 128'h10e, 1'b0, 8, 1'b0);
    add(1, 2'd0, 3, 128'h21c, 1'b0, 8, 1'b1);
    for (int b = 0; b < 4; b++) add(1, 2'd2, b, 128'(b), 1'b0, 8, b == 3);
    add(2, 2'd0, 0, 128'h1, 1'b0, 0, 1'b0);
    add(2, 2'd0, 1, 128'h2, 1'b0, 0, 1'b0);
    add(2, 2'd0, 2, 128'h4, 1'b0, 0, 1'b0);
    add(2, 2'd0, 3, 128'h8, 1'b0, 0, 1'b1);
    for (int b = 0; b < 4; b++) add(2, 2'd2, b, 128'(b), 1'b0, 0, b == 3);
    s = SEED3;
    for (int b = 0; b < 64; b++) begin
      add(3, 2'd1, b, s[0] ? FIX_C : s, s[0], 2, b == 63);
      s = lfsr_model(s);
    end

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.blk == 0) start_run(v.dut, v.md);
      run_block(v.dut, 1'b1, t, c, ix);
      chk($sformatf("text d%0d m%0d b%0d", v.dut, v.md, v.blk), t, v.text);
      chk($sformatf("class d%0d m%0d b%0d", v.dut, v.md, v.blk), 128'(c), 128'(v.cls));
      chk($sformatf("idx d%0d m%0d b%0d", v.dut, v.md, v.blk), 128'(ix), 128'(v.blk));
      if (v.last) begin
        chk($sformatf("end d%0d m%0d", v.dut, v.md),
            128'({tv[v.dut], busy[v.dut], done[v.dut]}), 128'd1);
      end else begin
        measure_gap(v.dut, g);
        chk($sformatf("gap d%0d m%0d b%0d", v.dut, v.md, v.blk), 128'(g), 128'(v.gap));
      end
    end

    // text_ready held low: block stays presented, no trigger.
    text_ready = 1'b0;
    start_run(0, 2'd0);
    chk("restart_done_clr", 128'(done[0]), 128'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 128'(tv[0]), 128'd1);
      chk("hold_text", txt[0], 128'h1);
      chk("hold_trig", 128'(trig[0]), 128'd0);
      @(negedge clk);
    end
    run_block(0, 1'b1, t, c, ix);
    chk("hold_text_hs", t, 128'h1);

    // Extra aes_done pulses during GAP are ignored.
    aes_done[0] = 1'b1; @(negedge clk);
    aes_done[0] = 1'b0; @(negedge clk);
    aes_done[0] = 1'b1; @(negedge clk);
    aes_done[0] = 1'b0;
    chk("gap_busy", 128'({busy[0], tv[0]}), 128'd2);
    measure_gap(0, g);
    chk("gap_extra_done", 128'(g), 128'd5);
    run_block(0, 1'b1, t, c, ix);
    chk("after_gap_text", t, 128'h2);
    chk("after_gap_idx", 128'(ix), 128'd1);
    measure_gap(0, g);

    // Abort while waiting on block 2.
    run_block(0, 1'b0, t, c, ix);
    chk("pre_abort_idx", 128'(idx[0]), 128'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ctl", 128'({tv[0], busy[0], done[0], trig[0]}), 128'd0);
    chk("abort_idx", 128'(idx[0]), 128'd2);
    start[0] = 1'b1; abort = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort = 1'b0;
    chk("abort_over_start", 128'({tv[0], busy[0]}), 128'd0);
    chk("abort_over_start_idx", 128'(idx[0]), 128'd2);

    // Reset during ISSUE with ready high: no trigger, everything cleared.
    text_ready = 1'b0;
    start_run(0, 2'd0);
    chk("issue_before_rst", 128'(tv[0]), 128'd1);
    text_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_no_trig", 128'(trig[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_ctl", 128'({tv[0], trig[0], busy[0], done[0], cls[0]}), 128'd0);
    chk("rst2_text", txt[0], 128'd0);
    chk("rst2_idx", 128'(idx[0]), 128'd0);
    chk("rst2_key", key[0], 128'd0);

    // Restart after reset begins again from the seed.
    start_run(0, 2'd0);
    run_block(0, 1'b1, t, c, ix);
    chk("restart_text0", t, 128'h1);
    chk("restart_idx0", 128'(ix), 128'd0);
    measure_gap(0, g);
    chk("restart_gap", 128'(g), 128'd8);
    run_block(0, 1'b1, t, c, ix);
    chk("restart_text1", t, 128'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
